// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for a combinational ALU: queues {a, b, mode, chain} commands,
// issues them one at a time on registered ALU lines and returns each result on a valid/ready channel.
module alu_cmd_sequencer #(
    parameter int DATA_WIDTH = 100,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    input  logic [1:0]            cmd_mode,
    input  logic                  cmd_chain,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [1:0]            alu_mode,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_mode,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  ops_done
);
    localparam int              PTR_W    = $clog2(FIFO_DEPTH);
    localparam int              ENT_W    = 2 * DATA_WIDTH + 3;
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESPOND} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ENT_W-1:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;
    logic [DATA_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_b;
    logic [1:0]            r_alu_mode;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [1:0]            r_rsp_mode;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_last;
    logic [CNT_WIDTH-1:0]  r_ops;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_head_a;
    logic [DATA_WIDTH-1:0] w_head_b;
    logic [1:0]            w_head_mode;
    logic                  w_head_chain;

    assign cmd_ready = (r_count != FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_push    = cmd_valid && cmd_ready;
    assign w_pop     = (r_state == S_ISSUE);
    assign {w_head_a, w_head_b, w_head_mode, w_head_chain} = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_a, cmd_b, cmd_mode, cmd_chain};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            // Leaving IDLE on the accepting edge lets a lone command issue on the next edge.
            S_IDLE:    if (!w_empty || w_push) w_next = S_ISSUE;
            S_ISSUE:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_RESPOND;
            S_RESPOND: if (rsp_ready) w_next = w_empty ? S_IDLE : S_ISSUE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_mode  <= '0;
            r_rsp_data  <= '0;
            r_rsp_mode  <= '0;
            r_rsp_valid <= 1'b0;
            r_last      <= '0;
            r_ops       <= '0;
        end else begin
            case (r_state)
                S_ISSUE: begin
                    r_alu_a    <= w_head_chain ? r_last : w_head_a;
                    r_alu_b    <= w_head_b;
                    r_alu_mode <= w_head_mode;
                end
                S_CAPTURE: begin
                    r_rsp_data  <= alu_result;
                    r_rsp_mode  <= r_alu_mode;
                    r_last      <= alu_result;
                    r_rsp_valid <= 1'b1;
                end
                S_RESPOND: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ops       <= r_ops + CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_mode  = r_alu_mode;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_mode  = r_rsp_mode;
    assign ops_done  = r_ops;
    assign busy      = !w_empty || (r_state != S_IDLE);
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: table-driven single ops, directed
// multi-cycle sequences and randomized traffic against an in-order result model.
module tb_alu_cmd_sequencer;
    localparam int DW = 8;
    localparam int FD = 4;
    localparam int CW = 2;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [1:0]    mode;
        logic          chain;
        logic [DW-1:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] cmd_a = '0;
    logic [DW-1:0] cmd_b = '0;
    logic [1:0]    cmd_mode = '0;
    logic          cmd_chain = 1'b0;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [1:0]    alu_mode;
    logic [DW-1:0] alu_result;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_mode;
    logic          busy;
    logic [CW-1:0] ops_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [DW+1:0] obs_q[$];
    int            obs_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [1:0] m);
        case (m)
            2'd0:    return a + b;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return ~a;
        endcase
    endfunction

    // The attached ALU
    always_comb alu_result = alu_ref(alu_a, alu_b, alu_mode);

    alu_cmd_sequencer #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(FD),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_mode  (cmd_mode),
        .cmd_chain (cmd_chain),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_mode  (alu_mode),
        .alu_result(alu_result),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_mode  (rsp_mode),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            obs_q.push_back({rsp_mode, rsp_data});
            obs_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        cmd_a     = v.a;
        cmd_b     = v.b;
        cmd_mode  = v.mode;
        cmd_chain = v.chain;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_mode  = '0;
        cmd_chain = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic single_op(input vec_t v, input int exp_ops, input string tag);
        drive(v);
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk); chk({tag, "_rdy"}, cmd_ready, 1);
        step(); cmd_valid = 1'b0;
        @(negedge clk); chk({tag, "_busy"}, busy, 1); chk({tag, "_v0"}, rsp_valid, 0);
        step();
        @(negedge clk); chk({tag, "_alub"}, alu_b, v.b); chk({tag, "_alum"}, alu_mode, v.mode);
        chk({tag, "_v1"}, rsp_valid, 0);
        step();
        @(negedge clk); chk({tag, "_valid"}, rsp_valid, 1); chk({tag, "_data"}, rsp_data, v.exp);
        chk({tag, "_mode"}, rsp_mode, v.mode);
        step();
        @(negedge clk); chk({tag, "_vdrop"}, rsp_valid, 0);
        chk({tag, "_ops"}, ops_done, exp_ops % 4); chk({tag, "_idle"}, busy, 0);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl[8];
        vec_t          bp[6];
        int            wrap_seq[5];
        logic [DW-1:0] bp_exp[6];
        logic [DW-1:0] last;
        logic [DW+1:0] exp_q[$];
        logic [DW-1:0] r;
        int            t;
        int            acc_cyc;
        bit            acc6;

        tbl[0] = '{8'h0F, 8'h01, 2'd0, 1'b0, 8'h10};
        tbl[1] = '{8'hF0, 8'h3C, 2'd0, 1'b0, 8'h2C};
        tbl[2] = '{8'hF0, 8'h3C, 2'd1, 1'b0, 8'h30};
        tbl[3] = '{8'hF0, 8'h3C, 2'd2, 1'b0, 8'hFC};
        tbl[4] = '{8'hF0, 8'h3C, 2'd3, 1'b0, 8'h0F};
        tbl[5] = '{8'h05, 8'h03, 2'd0, 1'b0, 8'h08};
        tbl[6] = '{8'hAA, 8'hFF, 2'd0, 1'b1, 8'h07};
        tbl[7] = '{8'h00, 8'h00, 2'd3, 1'b0, 8'hFF};
        wrap_seq = '{1, 2, 3, 0, 1};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_valid", rsp_valid, 0); chk("rst_ops", ops_done, 0); chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1); chk("rst_alua", alu_a, 0); chk("rst_data", rsp_data, 0);
        step();

        // Table of single ops, including chaining with wrap
        for (int i = 0; i < 8; i++) single_op(tbl[i], i + 1, $sformatf("tbl%0d", i));

        // Counter wrap from a fresh reset
        do_reset();
        for (int i = 0; i < 5; i++) single_op(tbl[i], wrap_seq[i], $sformatf("wrap%0d", i));

        // Reset while a response is pending and commands are queued
        do_reset();
        single_op(tbl[0], 1, "pre");
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive('{8'(8'h11 * (k + 1)), 8'h01, 2'd0, 1'b0, 8'h00});
            cmd_valid = 1'b1;
            step();
        end
        cmd_valid = 1'b0;
        for (t = 0; t < 10; t++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        chk("mid_pending", rsp_valid, 1);
        chk("mid_data_pre", rsp_data, 8'h12);
        #2 rst_n = 1'b0;
        obs_q.delete();
        obs_cyc.delete();
        #1;
        chk("mid_valid", rsp_valid, 0); chk("mid_data", rsp_data, 0); chk("mid_alua", alu_a, 0);
        chk("mid_alub", alu_b, 0); chk("mid_alum", alu_mode, 0); chk("mid_rmode", rsp_mode, 0);
        chk("mid_ops", ops_done, 0); chk("mid_busy", busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk); chk("mid_ready", cmd_ready, 1); chk("mid_busy2", busy, 0);
        repeat (8) @(negedge clk);
        chk("mid_norsp", obs_q.size(), 0); chk("mid_busy3", busy, 0);
        step();

        // All four modes back-to-back
        do_reset();
        rsp_ready = 1'b1;
        acc_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            drive('{8'hF0, 8'h3C, 2'(k), 1'b0, 8'h00});
            cmd_valid = 1'b1;
            @(negedge clk); chk($sformatf("modes_rdy%0d", k), cmd_ready, 1);
            if (k == 0) acc_cyc = cyc;
            step();
        end
        cmd_valid = 1'b0;
        for (t = 0; t < 40; t++) begin
            @(negedge clk);
            if (obs_q.size() >= 4) break;
        end
        chk("modes_cnt", obs_q.size(), 4);
        if (obs_q.size() == 4) begin
            // accepted at the edge after acc_cyc, result visible two edges later
            chk("modes_lat", obs_cyc[0] - acc_cyc, 3);
            for (int k = 0; k < 4; k++)
                chk($sformatf("modes_rsp%0d", k), obs_q[k], {2'(k), tbl[k + 1].exp});
            for (int k = 1; k < 4; k++)
                chk($sformatf("modes_gap%0d", k), obs_cyc[k] - obs_cyc[k - 1], 3);
        end
        step();

        // Backpressure until full, then drain
        do_reset();
        bp[0] = '{8'h21, 8'h13, 2'd0, 1'b0, 8'h00};
        bp[1] = '{8'h00, 8'h0F, 2'd0, 1'b1, 8'h00};
        bp[2] = '{8'h5A, 8'hF0, 2'd1, 1'b0, 8'h00};
        bp[3] = '{8'h00, 8'h34, 2'd2, 1'b1, 8'h00};
        bp[4] = '{8'h80, 8'h80, 2'd0, 1'b0, 8'h00};
        bp[5] = '{8'h00, 8'h01, 2'd0, 1'b1, 8'h00};
        last = '0;
        for (int k = 0; k < 6; k++) begin
            bp_exp[k] = alu_ref(bp[k].chain ? last : bp[k].a, bp[k].b, bp[k].mode);
            last = bp_exp[k];
        end
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(bp[k]);
            cmd_valid = 1'b1;
            @(negedge clk); chk($sformatf("bp_rdy%0d", k), cmd_ready, 1);
            step();
        end
        drive(bp[5]);
        @(negedge clk);
        chk("bp_full", cmd_ready, 0); chk("bp_valid", rsp_valid, 1); chk("bp_data", rsp_data, bp_exp[0]);
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge clk);
            chk("bp_hold_rdy", cmd_ready, 0); chk("bp_hold_data", rsp_data, bp_exp[0]);
            chk("bp_hold_valid", rsp_valid, 1);
        end
        step();
        rsp_ready = 1'b1;
        acc6 = 1'b0;
        for (t = 0; t < 80; t++) begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) acc6 = 1'b1;
            if (obs_q.size() >= 6) break;
            step();
            if (acc6) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        chk("bp_acc6", acc6, 1);
        chk("bp_cnt", obs_q.size(), 6);
        if (obs_q.size() == 6)
            for (int k = 0; k < 6; k++)
                chk($sformatf("bp_rsp%0d", k), obs_q[k], {bp[k].mode, bp_exp[k]});
        step();

        // Randomized traffic against the in-order model
        do_reset();
        last = '0;
        for (int n = 0; n < 600; n++) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_a     = 8'($urandom);
            cmd_b     = 8'($urandom);
            cmd_mode  = 2'($urandom);
            cmd_chain = ($urandom_range(0, 3) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                r = alu_ref(cmd_chain ? last : cmd_a, cmd_b, cmd_mode);
                last = r;
                exp_q.push_back({cmd_mode, r});
            end
            step();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (!busy && !rsp_valid) break;
        end
        chk("rnd_drain", busy, 0);
        chk("rnd_cnt", obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            chk($sformatf("rnd_rsp%0d", k), obs_q[k], exp_q[k]);
        chk("rnd_ops", ops_done, exp_q.size() % 4);
        chk("rnd_ready", cmd_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
